bf_mem_sequencer: RTL
=====================

Name: bf_mem_sequencer

Overview:
Owns the brainfuck core's code memory and data memory and sequences them. It clears the data array, loads a program byte stream from a host into code memory, then hands both memories to the core and releases it to run. It sits between brainfuckCore, ramDualAccess (data) and a writable code RAM. It drives the core's run enable and multiplexes each memory's address, write-data and write-enable between itself and the core.

Parameters:
CODE_ADDR_W, 5, code memory address width (depth 2^CODE_ADDR_W bytes)
DATA_ADDR_W, 5, data array address width (depth 2^DATA_ADDR_W bytes)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
load_start  in  1  pulse: clear data array, load new program, then run
run_start  in  1  pulse: clear data array and rerun the stored program
stop  in  1  pulse: halt core, return to IDLE
host_valid  in  1  host program byte valid
host_data  in  8  host program byte; 0x00 terminates the program
host_ready  out  1  sequencer accepts host byte this cycle
core_run  out  1  1 = core enabled (drives core's reset/enable pin); 0 = core held
core_code_addr  in  CODE_ADDR_W  core code fetch address
code_addr  out  CODE_ADDR_W  code RAM address
code_wdata  out  8  code RAM write data
code_we  out  1  code RAM write enable
core_data_addr  in  DATA_ADDR_W  core data array address
core_data_out  in  8  core write data
core_write_rq  in  1  core write request
data_addr  out  DATA_ADDR_W  data RAM address
data_wdata  out  8  data RAM write data
data_we  out  1  data RAM write enable
prog_len  out  CODE_ADDR_W  index of the stored terminator byte (program length)
prog_valid  out  1  a complete program is stored
load_err  out  1  last load overflowed code memory without a terminator
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, CLEAR, LOAD, RUN. The state register, counters and flags are registered. The memory muxes, host_ready, core_run and busy decode combinationally from state.
- Reset (synchronous): state=IDLE; counters=0; prog_len=0; prog_valid=0; load_err=0. Consequently host_ready=0, core_run=0, code_we=0, data_we=0, busy=0. Reset mid-CLEAR, LOAD or RUN aborts immediately; a partially written memory is left as is.
- IDLE: both write enables are 0. code_addr=core_code_addr and data_addr=core_data_addr, wdata=0.
  - load_start -> CLEAR, with the after-clear target set to LOAD.
  - run_start with prog_valid=1 -> CLEAR, with the after-clear target set to RUN.
  - run_start with prog_valid=0 is ignored.
  - If load_start and run_start arrive together, load_start wins.
- CLEAR: data_we=1, data_wdata=0, data_addr=clr_cnt. clr_cnt starts at 0 and increments each cycle.
  - On the cycle clr_cnt = 2^DATA_ADDR_W-1, the next state is the after-clear target. The clear therefore takes exactly 2^DATA_ADDR_W cycles.
  - Entering LOAD: ld_cnt=0, prog_valid=0, load_err=0.
  - load_start, run_start and stop are ignored during CLEAR.
- LOAD: host_ready=1. On host_valid: code_we=1, code_addr=ld_cnt, code_wdata=host_data. host_valid with host_ready=0 is never consumed.
  - If host_data==0x00: prog_len=ld_cnt, prog_valid=1, next state RUN. The terminator byte is stored.
  - Else if ld_cnt = 2^CODE_ADDR_W-1: load_err=1, prog_valid=0, next state IDLE.
  - Else: ld_cnt+1.
  - stop in LOAD -> IDLE, with prog_valid=0. This takes priority over a same-cycle byte, which is not written.
- RUN: core_run=1. The code port passes core_code_addr with we=0. The data port passes core_data_addr, core_data_out and core_write_rq.
  - core_run asserts in the first cycle after the terminator is accepted or the clear completes.
  - stop -> IDLE; core_run drops in the next cycle.
  - load_start -> CLEAR/LOAD, aborting the run. It wins over a same-cycle stop.
  - run_start -> CLEAR/RUN, restarting the core with a clean array.
- Counter widths equal the corresponding address widths. The terminal-count compare prevents wrap; a counter never wraps past max.

Decomposition:
- Shared package bf_pkg: state encoding (IDLE=2'd0, CLEAR=2'd1, LOAD=2'd2, RUN=2'd3) and the constant BF_PROG_END=8'h00. The core and loader share BF_PROG_END.
- One natural sub-module, bf_mem_port_mux: a combinational owner-select mux for one memory port, instantiated twice (code, data).

Test Plan:
- Reset 1 cycle, then idle 5 cycles -> core_run=0, busy=0, data_we=0, code_we=0, prog_valid=0.
- load_start, then host bytes "+", "+", ".", 0x00 with host_valid held -> data_we=1 for exactly 32 cycles at addresses 0..31 with data 0. Code RAM then holds 2B 2B 2E 00 at addresses 0..3, prog_len=3, prog_valid=1, and core_run=1 in the cycle after the 0x00 is accepted.
- Load 32 non-zero bytes (0x2B) with no terminator -> load_err=1, prog_valid=0, state IDLE, core_run stays 0.
- In RUN, core_write_rq=1, core_data_addr=5, core_data_out=0x7A -> data_we=1, data_addr=5, data_wdata=0x7A in the same cycle. Then stop -> core_run=0 next cycle; run_start -> 32-cycle clear, then core_run=1 with the code RAM untouched.
- In RUN, assert load_start and stop in the same cycle -> the CLEAR path is taken with target LOAD and host_ready=1 after the clear. Separately, run_start with prog_valid=0 in IDLE -> no state change.
- Assert reset in the middle of CLEAR at clr_cnt=10 -> next cycle data_we=0, state IDLE, all flags 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck memory sequencer and core:
// sequencer state encoding and the program terminator byte.
package bf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } bf_state_t;

    localparam logic [7:0] BF_PROG_END = 8'h00;

endpackage

// File: rtl/bf_mem_port_mux.sv
// Owner-select mux for one memory port. The sequencer side wins when it
// owns the port; otherwise the core address always passes, while the core
// write path only passes when the core is allowed to write.
module bf_mem_port_mux #(
    parameter int ADDR_W = 5
) (
    input  logic              seq_own,
    input  logic              core_pass,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [7:0]        seq_wdata,
    input  logic              seq_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_wdata,
    input  logic              core_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we
);

    // Select the port owner; the core write path is gated when not running
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        if (seq_own) begin
            mem_addr  = seq_addr;
            mem_wdata = seq_wdata;
            mem_we    = seq_we;
        end else if (core_pass) begin
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end
    end

endmodule

// File: rtl/bf_mem_sequencer.sv
// Sequences code and data memories for the brainfuck core: clears the data
// array, loads a host program into code RAM, then releases the core to run.
module bf_mem_sequencer
    import bf_pkg::*;
#(
    parameter int CODE_ADDR_W = 5,
    parameter int DATA_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   run_start,
    input  logic                   stop,
    input  logic                   host_valid,
    input  logic [7:0]             host_data,
    output logic                   host_ready,
    output logic                   core_run,
    input  logic [CODE_ADDR_W-1:0] core_code_addr,
    output logic [CODE_ADDR_W-1:0] code_addr,
    output logic [7:0]             code_wdata,
    output logic                   code_we,
    input  logic [DATA_ADDR_W-1:0] core_data_addr,
    input  logic [7:0]             core_data_out,
    input  logic                   core_write_rq,
    output logic [DATA_ADDR_W-1:0] data_addr,
    output logic [7:0]             data_wdata,
    output logic                   data_we,
    output logic [CODE_ADDR_W-1:0] prog_len,
    output logic                   prog_valid,
    output logic                   load_err,
    output logic                   busy
);

    localparam logic [CODE_ADDR_W-1:0] CODE_MAX = '1;
    localparam logic [DATA_ADDR_W-1:0] DATA_MAX = '1;

    bf_state_t              state, state_next;
    logic [DATA_ADDR_W-1:0] clr_cnt, clr_cnt_next;
    logic [CODE_ADDR_W-1:0] ld_cnt, ld_cnt_next;
    logic [CODE_ADDR_W-1:0] prog_len_next;
    logic                   clr_to_load, clr_to_load_next;
    logic                   prog_valid_next;
    logic                   load_err_next;

    // State, counters and program flags; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            ld_cnt      <= '0;
            clr_to_load <= 1'b0;
            prog_len    <= '0;
            prog_valid  <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state       <= state_next;
            clr_cnt     <= clr_cnt_next;
            ld_cnt      <= ld_cnt_next;
            clr_to_load <= clr_to_load_next;
            prog_len    <= prog_len_next;
            prog_valid  <= prog_valid_next;
            load_err    <= load_err_next;
        end
    end

    // Next-state and register updates; load_start outranks run_start and stop
    always_comb begin
        state_next       = state;
        clr_cnt_next     = clr_cnt;
        ld_cnt_next      = ld_cnt;
        clr_to_load_next = clr_to_load;
        prog_len_next    = prog_len;
        prog_valid_next  = prog_valid;
        load_err_next    = load_err;
        unique case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next       = ST_CLEAR;
                    clr_cnt_next     = '0;
                    clr_to_load_next = 1'b1;
                end else if (run_start && prog_valid) begin
                    state_next       = ST_CLEAR;
                    clr_cnt_next     = '0;
                    clr_to_load_next = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt == DATA_MAX) begin
                    if (clr_to_load) begin
                        state_next      = ST_LOAD;
                        ld_cnt_next     = '0;
                        prog_valid_next = 1'b0;
                        load_err_next   = 1'b0;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    clr_cnt_next = clr_cnt + 1'b1;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_next      = ST_IDLE;
                    prog_valid_next = 1'b0;
                end else if (host_valid) begin
                    if (host_data == BF_PROG_END) begin
                        prog_len_next   = ld_cnt;
                        prog_valid_next = 1'b1;
                        state_next      = ST_RUN;
                    end else if (ld_cnt == CODE_MAX) begin
                        load_err_next   = 1'b1;
                        prog_valid_next = 1'b0;
                        state_next      = ST_IDLE;
                    end else begin
                        ld_cnt_next = ld_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_next       = ST_CLEAR;
                    clr_cnt_next     = '0;
                    clr_to_load_next = 1'b1;
                end else if (run_start) begin
                    state_next       = ST_CLEAR;
                    clr_cnt_next     = '0;
                    clr_to_load_next = 1'b0;
                end else if (stop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and core enable decode straight from the state
    always_comb begin
        host_ready = (state == ST_LOAD);
        core_run   = (state == ST_RUN);
        busy       = (state != ST_IDLE);
    end

    bf_mem_port_mux #(.ADDR_W(CODE_ADDR_W)) u_code_mux (
        .seq_own    (state == ST_LOAD),
        .core_pass  (1'b0),
        .seq_addr   (ld_cnt),
        .seq_wdata  (host_data),
        .seq_we     (host_valid && !stop),
        .core_addr  (core_code_addr),
        .core_wdata (8'h00),
        .core_we    (1'b0),
        .mem_addr   (code_addr),
        .mem_wdata  (code_wdata),
        .mem_we     (code_we)
    );

    bf_mem_port_mux #(.ADDR_W(DATA_ADDR_W)) u_data_mux (
        .seq_own    (state == ST_CLEAR),
        .core_pass  (state == ST_RUN),
        .seq_addr   (clr_cnt),
        .seq_wdata  (8'h00),
        .seq_we     (1'b1),
        .core_addr  (core_data_addr),
        .core_wdata (core_data_out),
        .core_we    (core_write_rq),
        .mem_addr   (data_addr),
        .mem_wdata  (data_wdata),
        .mem_we     (data_we)
    );

endmodule
